// File: rtl/sort_ctrl.sv
// sort_ctrl: sequencer for the SR-latch bit-sorting array.
// Captures an oversampled word, runs one precharge phase and one sort phase,
// registers the sorted thermometer word and its ones-count, and hands the
// result to a consumer over a valid/ready handshake.
// Optional feature macro: SORT_CTRL_POPCHK_EN (input/output popcount cross-check
// that adds the pop_err output).

module sort_ctrl #(
  parameter int SAMPLES    = 128,
  parameter int OSF        = 8,
  parameter int PRE_CYC    = 2,
  parameter int SETTLE_CYC = 8,
  localparam int N         = SAMPLES * OSF,
  localparam int CW        = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  in_data,
  output logic          busy,
  output logic          sort_p,
  output logic [N-1:0]  sort_din,
  input  logic [N-1:0]  sort_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic [N-1:0]  sorted_q,
`ifdef SORT_CTRL_POPCHK_EN
  output logic          pop_err,
`endif
  output logic          therm_err
);

  // The phase counter has to reach the longer of the two phase lengths.
  localparam int CNT_MAX = (PRE_CYC > SETTLE_CYC) ? PRE_CYC : SETTLE_CYC;
  localparam int CNTW    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNTW-1:0] PRE_LAST    = CNTW'(PRE_CYC - 1);
  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SORT  = 3'd2,
    CAPT  = 3'd3,
    VALID = 3'd4
  } state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0]   dout_pop;
  logic            shape_bad;

  // Count of ones in a sorter-wide word; wide enough to hold N itself.
  function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s = s + CW'(v[i]);
    end
    return s;
  endfunction

  // Ones-count of the word the sorter is presenting right now.
  always_comb begin
    dout_pop = popcnt(sort_dout);
  end

  // A legal thermometer word has no set bit sitting above a clear one.
  always_comb begin
    shape_bad = |(sort_dout[N-1:1] & ~sort_dout[N-2:0]);
  end

`ifdef SORT_CTRL_POPCHK_EN
  logic [CW-1:0] din_pop;
  logic          pop_bad;

  // Ones-count of the captured input, refreshed while the sorter works on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_pop <= '0;
    end else if (state == LOAD || state == SORT) begin
      din_pop <= popcnt(sort_din);
    end
  end

  // The sorter must neither lose nor duplicate a bit.
  always_comb begin
    pop_bad = (din_pop != dout_pop);
  end
`endif

  // Conversion sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sort_p    <= 1'b1;
      sort_din  <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      count     <= '0;
      sorted_q  <= '0;
      therm_err <= 1'b0;
`ifdef SORT_CTRL_POPCHK_EN
      pop_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          sort_p <= 1'b1;
          if (start) begin
            sort_din <= in_data;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          if (cnt == PRE_LAST) begin
            cnt    <= '0;
            sort_p <= 1'b0;
            state  <= SORT;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end

        SORT: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= CAPT;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end

        CAPT: begin
          sorted_q  <= sort_dout;
          count     <= dout_pop;
`ifdef SORT_CTRL_POPCHK_EN
          therm_err <= shape_bad | pop_bad;
          pop_err   <= pop_bad;
`else
          therm_err <= shape_bad;
`endif
          out_valid <= 1'b1;
          sort_p    <= 1'b1;
          state     <= VALID;
        end

        VALID: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          sort_p    <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_ctrl.sv
// tb_sort_ctrl: scoreboard bench for sort_ctrl with a behavioural sorter model.
// Stimulus pushes hand-computed expected results; a monitor checks each handshake.

module tb_sort_ctrl;

  localparam int SAMPLES = 128;
  localparam int OSF     = 8;
  localparam int N       = SAMPLES * OSF;
  localparam int CW      = $clog2(N + 1);
  localparam int LAT     = 11;

`ifdef SORT_CTRL_POPCHK_EN
  localparam logic POPCHK = 1'b1;
`else
  localparam logic POPCHK = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  in_data;
  logic          busy;
  logic          sort_p;
  logic [N-1:0]  sort_din;
  logic [N-1:0]  sort_dout;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic [N-1:0]  sorted_q;
  logic          therm_err;
  logic          pop_err_w;

  logic [1:0]    mode;

  typedef struct {
    logic [CW-1:0] count;
    logic [N-1:0]  sorted;
    logic          therm;
    logic          pop;
    int            acc;
  } exp_t;

  exp_t sb[$];

  int checks;
  int errors;
  int cyc;

  sort_ctrl #(
    .SAMPLES(SAMPLES), .OSF(OSF), .PRE_CYC(2), .SETTLE_CYC(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .in_data(in_data),
    .busy(busy),
    .sort_p(sort_p),
    .sort_din(sort_din),
    .sort_dout(sort_dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count(count),
    .sorted_q(sorted_q),
`ifdef SORT_CTRL_POPCHK_EN
    .pop_err(pop_err_w),
`endif
    .therm_err(therm_err)
  );

`ifndef SORT_CTRL_POPCHK_EN
  assign pop_err_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] ones(input int n);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  // Sorter model: precharged to zero while P is high; mode 1 returns an
  // illegal shape, mode 2 loses one bit.
  always_comb begin
    int pc;
    pc = 0;
    sort_dout = '0;
    for (int i = 0; i < N; i++) pc = pc + int'(sort_din[i]);
    if (!sort_p) begin
      case (mode)
        2'd0:    sort_dout = ones(pc);
        2'd1:    sort_dout = {{(N-3){1'b0}}, 3'b101};
        2'd2:    sort_dout = ones(pc - 1);
        default: sort_dout = '0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkWide(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got low64 %h (ones %0d) expected low64 %h (ones %0d)",
               name, act[63:0], $countones(act), exp[63:0], $countones(exp));
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_sort_p"}, 64'(sort_p), 64'd1);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_count"}, 64'(count), 64'd0);
    checkOutput({tag, "_therm_err"}, 64'(therm_err), 64'd0);
    checkOutput({tag, "_pop_err"}, 64'(pop_err_w), 64'd0);
    checkWide({tag, "_sort_din"}, sort_din, '0);
    checkWide({tag, "_sorted_q"}, sorted_q, '0);
  endtask

  // Issue one accepted conversion and queue its expected result.
  task automatic applyStimulus(input logic [N-1:0] d, input int c, input logic [N-1:0] s,
                               input logic t, input logic p);
    exp_t e;
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) failNow("wait_idle");
    in_data = d;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("accept_busy", 64'(busy), 64'd1);
    e.count  = CW'(c);
    e.sorted = s;
    e.therm  = t;
    e.pop    = p;
    e.acc    = cyc;
    sb.push_back(e);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) failNow("drain");
  endtask

  // Monitor: latency on each rising out_valid, full compare at each handshake.
  initial begin
    logic prev_valid;
    logic hs_seen;
    exp_t e;
    prev_valid = 1'b0;
    hs_seen    = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_valid = 1'b0;
        hs_seen    = 1'b0;
        continue;
      end
      if (hs_seen) begin
        checkOutput("valid_drop_after_hs", 64'(out_valid), 64'd0);
        hs_seen = 1'b0;
      end
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid: got out_valid with count %0d, expected no result", count);
        end else begin
          checkOutput("latency", 64'(cyc - sb[0].acc), 64'(LAT));
        end
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("count", 64'(count), 64'(e.count));
        checkWide("sorted_q", sorted_q, e.sorted);
        checkOutput("therm_err", 64'(therm_err), 64'(e.therm));
        checkOutput("pop_err", 64'(pop_err_w), 64'(e.pop));
        hs_seen = 1'b1;
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [N-1:0] d;
    int hi, lo, din_ok, stable, n;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    mode      = 2'd0;
    repeat (3) @(negedge clk);
    checkReset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero word.
    applyStimulus('0, 0, '0, 1'b0, 1'b0);
    waitDrain();

    // All-ones word needs the full count width.
    applyStimulus('1, 1024, '1, 1'b0, 1'b0);
    waitDrain();

    // Alternating pattern, with the P profile: 2 precharge cycles, then
    // 8 settle cycles plus the capture cycle low.
    d = {(N/2){2'b10}};
    applyStimulus(d, 512, ones(512), 1'b0, 1'b0);
    hi = 0; lo = 0; din_ok = 1;
    for (int i = 0; i < 11; i++) begin
      if (sort_p && lo == 0) hi++;
      else if (!sort_p) lo++;
      if (sort_din !== d) din_ok = 0;
      @(negedge clk);
    end
    checkOutput("p_high_cycles", 64'(hi), 64'd2);
    checkOutput("p_low_cycles", 64'(lo), 64'd9);
    checkOutput("sort_din_const", 64'(din_ok), 64'd1);
    waitDrain();

    // Back-to-back: start held across the handshake, accepted on the next edge.
    d = '0; d[7:4] = 4'hF;
    applyStimulus(d, 4, ones(4), 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) failNow("b2b_wait_valid");
    d = '0; d[1:0] = 2'b11;
    in_data = d;
    start   = 1'b1;
    @(negedge clk);
    checkOutput("b2b_idle_after_hs", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_accept_busy", 64'(busy), 64'd1);
    begin
      exp_t e;
      e.count = CW'(2); e.sorted = ones(2); e.therm = 1'b0; e.pop = 1'b0; e.acc = cyc;
      sb.push_back(e);
    end
    waitDrain();

    // Start during SORT is ignored; result held while out_ready stays low.
    out_ready = 1'b0;
    d = '0; d[15:8] = 8'hFF;
    applyStimulus(d, 8, ones(8), 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    in_data = '1;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    in_data = '0;
    checkWide("ignored_start_din", sort_din, d);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) failNow("hold_wait_valid");
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && count == CW'(8) && sorted_q == ones(8)) stable++;
      @(negedge clk);
    end
    checkOutput("hold_stable_cycles", 64'(stable), 64'd20);
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput("ignored_start_not_queued", 64'(busy), 64'd0);
      @(negedge clk);
    end
    checkOutput("result_held_after_hs", 64'(count), 64'd8);
    waitDrain();

    // Illegal shape from the sorter.
    mode = 2'd1;
    d = '0; d[1:0] = 2'b11;
    applyStimulus(d, 2, ones(3) & ~ones(2) | ones(1), 1'b1, 1'b0);
    waitDrain();

    // Sorter loses a bit: legal shape, count mismatch.
    mode = 2'd2;
    d = '0; d[2:0] = 3'b111;
    applyStimulus(d, 2, ones(2), POPCHK, POPCHK);
    waitDrain();
    mode = 2'd0;

    // Reset mid-SORT aborts; the restart carries no stale data.
    d = '0; d[15:0] = 16'hFFFF;
    applyStimulus(d, 16, ones(16), 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    checkReset("abort");
    rst_n = 1'b1;
    @(negedge clk);
    d = '0; d[1:0] = 2'b11;
    applyStimulus(d, 2, ones(2), 1'b0, 1'b0);
    waitDrain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
